// File: rtl/atm_account_arbiter_if.sv
// Request/response bundle between the ATM front ends and the shared-account arbiter.
// Per-port fields are packed side by side; port p occupies slice p of each vector.
interface atm_account_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int ID_W    = 4,
    parameter int AMT_W   = 32
);
    logic [N_PORTS-1:0]       REQ;
    logic [2*N_PORTS-1:0]     OP;
    logic [ID_W*N_PORTS-1:0]  CARD;
    logic [AMT_W*N_PORTS-1:0] AMOUNT;
    logic [N_PORTS-1:0]       ACK;
    logic [2:0]               RESP_PORT;
    logic                     RESP_OK;
    logic [AMT_W-1:0]         RESP_BAL;
    logic                     BUSY;

    modport master (
        output REQ, OP, CARD, AMOUNT,
        input  ACK, RESP_PORT, RESP_OK, RESP_BAL, BUSY
    );

    modport slave (
        input  REQ, OP, CARD, AMOUNT,
        output ACK, RESP_PORT, RESP_OK, RESP_BAL, BUSY
    );
endinterface

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter that serialises ATM transactions onto one balance table.
// Exactly one read-modify-write is in flight, so same-account updates never interleave.
module atm_account_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DB_SIZE = 10,
    parameter int ID_W    = 4,
    parameter int AMT_W   = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    atm_account_arbiter_if.slave  bus
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gnt_q, gnt_d;
    logic [1:0]         op_q, op_d;
    logic [ID_W-1:0]    card_q, card_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [AMT_W-1:0]   bal_q, bal_d;
    logic               inv_q, inv_d;
    logic [N_PORTS-1:0] ack_q, ack_d;
    logic [2:0]         resp_port_q, resp_port_d;
    logic               resp_ok_q, resp_ok_d;
    logic [AMT_W-1:0]   resp_bal_q, resp_bal_d;
    logic               busy_q, busy_d;
    logic [AMT_W-1:0]   tbl_q [DB_SIZE];

    logic [PW:0]        pick_s;
    logic [PW-1:0]      pick_idx_s;
    logic [AMT_W:0]     ex_sum_s;
    logic               ex_ok_s;
    logic [AMT_W-1:0]   ex_new_s;
    logic               wr_en_s;

    function automatic logic [AMT_W-1:0] init_bal(input int idx);
        logic [63:0] v;
        v = 64'(idx) * 64'(idx) * 64'(idx) * 64'(idx);
        return v[AMT_W-1:0];
    endfunction

    // Returns {found, index} of the first request strictly after ptr, wrapping around.
    function automatic logic [PW:0] rr_pick(input logic [N_PORTS-1:0] req,
                                            input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(ptr) + k) % N_PORTS;
            if (!res[PW] && req[idx]) begin
                res = {1'b1, PW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin grant candidate from the live request levels.
    always_comb begin
        pick_s     = rr_pick(bus.REQ, ptr_q);
        pick_idx_s = pick_s[PW-1:0];
    end

    // Arithmetic of the latched operation against the loaded balance.
    always_comb begin
        ex_sum_s = {1'b0, bal_q} + {1'b0, amt_q};
        ex_ok_s  = 1'b0;
        ex_new_s = bal_q;
        if (inv_q) begin
            ex_ok_s  = 1'b0;
            ex_new_s = bal_q;
        end else begin
            case (op_q)
                2'b00: begin
                    ex_ok_s  = (amt_q <= bal_q);
                    ex_new_s = ex_ok_s ? (bal_q - amt_q) : bal_q;
                end
                2'b01: begin
                    ex_ok_s  = (bal_q != '0);
                    ex_new_s = bal_q;
                end
                2'b10: begin
                    ex_ok_s  = ~ex_sum_s[AMT_W];
                    ex_new_s = ex_ok_s ? ex_sum_s[AMT_W-1:0] : bal_q;
                end
                default: begin
                    ex_ok_s  = 1'b0;
                    ex_new_s = bal_q;
                end
            endcase
        end
    end

    // Next-state and registered-output logic of the transaction FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        card_d      = card_q;
        amt_d       = amt_q;
        bal_d       = bal_q;
        inv_d       = inv_q;
        ack_d       = '0;
        resp_port_d = resp_port_q;
        resp_ok_d   = resp_ok_q;
        resp_bal_d  = resp_bal_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (pick_s[PW]) begin
                    ptr_d   = pick_idx_s;
                    gnt_d   = pick_idx_s;
                    op_d    = bus.OP[2*int'(pick_idx_s) +: 2];
                    card_d  = bus.CARD[ID_W*int'(pick_idx_s) +: ID_W];
                    amt_d   = bus.AMOUNT[AMT_W*int'(pick_idx_s) +: AMT_W];
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (int'(card_q) < DB_SIZE) begin
                    bal_d = tbl_q[card_q];
                    inv_d = 1'b0;
                end else begin
                    bal_d = '0;
                    inv_d = 1'b1;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ack_d[gnt_q] = 1'b1;
                resp_port_d  = 3'(gnt_q);
                resp_ok_d    = ex_ok_s;
                resp_bal_d   = ex_new_s;
                state_d      = S_RESP;
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(N_PORTS - 1);
            gnt_q       <= '0;
            op_q        <= 2'b00;
            card_q      <= '0;
            amt_q       <= '0;
            bal_q       <= '0;
            inv_q       <= 1'b0;
            ack_q       <= '0;
            resp_port_q <= 3'd0;
            resp_ok_q   <= 1'b0;
            resp_bal_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            card_q      <= card_d;
            amt_q       <= amt_d;
            bal_q       <= bal_d;
            inv_q       <= inv_d;
            ack_q       <= ack_d;
            resp_port_q <= resp_port_d;
            resp_ok_q   <= resp_ok_d;
            resp_bal_q  <= resp_bal_d;
            busy_q      <= busy_d;
        end
    end

    // Only a successful withdraw or deposit writes back; inquiries never do.
    assign wr_en_s = (state_q == S_RESP) && resp_ok_q && (op_q == 2'b00 || op_q == 2'b10)
                     && (int'(card_q) < DB_SIZE);

    // Balance table: seeded on reset, committed at the end of the response cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DB_SIZE; i++) begin
                tbl_q[i] <= init_bal(i);
            end
        end else if (wr_en_s) begin
            tbl_q[card_q] <= resp_bal_q;
        end
    end

    assign bus.ACK       = ack_q;
    assign bus.RESP_PORT = resp_port_q;
    assign bus.RESP_OK   = resp_ok_q;
    assign bus.RESP_BAL  = resp_bal_q;
    assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_atm_account_arbiter.sv
// Bench for atm_account_arbiter: directed vector table, corner sequences and
// randomized traffic checked against an account-level reference model.
module tb_atm_account_arbiter;
    localparam int NP = 4;
    localparam int NDB = 10;

    logic CLK;
    logic RESET;

    atm_account_arbiter_if #(.N_PORTS(NP), .ID_W(4), .AMT_W(32)) bus ();

    atm_account_arbiter #(.N_PORTS(NP), .DB_SIZE(NDB), .ID_W(4), .AMT_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: account balances and the last served port.
    logic [31:0] mbal [NDB];
    int          mptr;

    int          op_v   [NP];
    int          card_v [NP];
    logic [31:0] amt_v  [NP];

    int          g_port [$];
    logic        g_ok   [$];
    logic [31:0] g_bal  [$];

    typedef struct {
        int          port;
        int          op;
        int          card;
        logic [31:0] amt;
        logic        ok;
        logic [31:0] bal;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDB; i++) begin
            longint v;
            v = longint'(i) ** 4;
            mbal[i] = v[31:0];
        end
        mptr = NP - 1;
    endtask

    task automatic model_txn(input int op, input int card, input logic [31:0] amt,
                             output logic ok, output logic [31:0] res);
        longint b;
        longint a;
        b   = (card < NDB) ? longint'(mbal[card]) : 64'd0;
        a   = longint'(amt);
        ok  = 1'b0;
        res = b[31:0];
        if (card < NDB) begin
            if (op == 0 && a <= b) begin
                ok  = 1'b1;
                res = 32'(b - a);
            end else if (op == 1) begin
                ok = (b > 0);
            end else if (op == 2 && (a + b) <= 64'hFFFF_FFFF) begin
                ok  = 1'b1;
                res = 32'(a + b);
            end
            if (ok && (op == 0 || op == 2)) mbal[card] = res;
        end
    endtask

    // Posts requests for the ports in mask and checks n_acks responses against the model.
    task automatic run_group(input logic [NP-1:0] mask, input int n_acks, input bit hold);
        logic [NP-1:0] pending;
        int            waited;
        int            expp;
        logic          eok;
        logic [31:0]   ebal;
        g_port.delete();
        g_ok.delete();
        g_bal.delete();
        for (int p = 0; p < NP; p++) begin
            bus.OP[2*p +: 2]      = 2'(op_v[p]);
            bus.CARD[4*p +: 4]    = 4'(card_v[p]);
            bus.AMOUNT[32*p +: 32] = amt_v[p];
        end
        bus.REQ = mask;
        pending = mask;
        ebal = 32'd0;
        for (int a = 0; a < n_acks; a++) begin
            expp = -1;
            for (int k = 1; k <= NP; k++) begin
                if (expp < 0 && pending[(mptr + k) % NP]) expp = (mptr + k) % NP;
            end
            model_txn(op_v[expp], card_v[expp], amt_v[expp], eok, ebal);
            mptr = expp;
            waited = 0;
            do begin
                @(posedge CLK); #1;
                waited++;
            end while (bus.ACK == '0 && waited < 20);
            check("ack_latency", 64'(waited), (a == 0) ? 64'd3 : 64'd4);
            check("ack_onehot", 64'(bus.ACK), 64'(1 << expp));
            check("resp_port", 64'(bus.RESP_PORT), 64'(expp));
            check("resp_ok", 64'(bus.RESP_OK), 64'(eok));
            check("resp_bal", 64'(bus.RESP_BAL), 64'(ebal));
            check("busy_at_ack", 64'(bus.BUSY), 64'd1);
            g_port.push_back(int'(bus.RESP_PORT));
            g_ok.push_back(bus.RESP_OK);
            g_bal.push_back(bus.RESP_BAL);
            if (!hold) begin
                pending[expp] = 1'b0;
                bus.REQ[expp] = 1'b0;
            end
        end
        bus.REQ = '0;
        @(posedge CLK); #1;
        check("ack_after", 64'(bus.ACK), 64'd0);
        check("busy_after", 64'(bus.BUSY), 64'd0);
        check("bal_hold", 64'(bus.RESP_BAL), 64'(ebal));
    endtask

    task automatic single(input int p, input int op, input int card, input logic [31:0] amt);
        op_v[p]   = op;
        card_v[p] = card;
        amt_v[p]  = amt;
        run_group(NP'(1 << p), 1, 1'b0);
    endtask

    initial begin
        vt[0]  = '{1, 1, 3,  32'd0,         1'b1, 32'd81};
        vt[1]  = '{0, 0, 2,  32'd100,       1'b0, 32'd16};
        vt[2]  = '{0, 0, 2,  32'd16,        1'b1, 32'd0};
        vt[3]  = '{0, 1, 2,  32'd0,         1'b0, 32'd0};
        vt[4]  = '{2, 2, 12, 32'd50,        1'b0, 32'd0};
        vt[5]  = '{3, 0, 12, 32'd0,         1'b0, 32'd0};
        vt[6]  = '{1, 2, 1,  32'hFFFF_FFFF, 1'b0, 32'd1};
        vt[7]  = '{3, 0, 4,  32'd0,         1'b1, 32'd256};
        vt[8]  = '{2, 3, 3,  32'd5,         1'b0, 32'd81};
        vt[9]  = '{1, 2, 2,  32'd10,        1'b1, 32'd10};
        vt[10] = '{0, 1, 0,  32'd0,         1'b0, 32'd0};
        vt[11] = '{3, 2, 0,  32'd7,         1'b1, 32'd7};
        vt[12] = '{2, 2, 6,  32'hFFFF_FAEF, 1'b1, 32'hFFFF_FFFF};
        vt[13] = '{2, 2, 6,  32'd1,         1'b0, 32'hFFFF_FFFF};

        for (int p = 0; p < NP; p++) begin
            op_v[p] = 0; card_v[p] = 0; amt_v[p] = 32'd0;
        end
        bus.REQ = '0; bus.OP = '0; bus.CARD = '0; bus.AMOUNT = '0;
        RESET = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ack", 64'(bus.ACK), 64'd0);
        check("rst_port", 64'(bus.RESP_PORT), 64'd0);
        check("rst_ok", 64'(bus.RESP_OK), 64'd0);
        check("rst_bal", 64'(bus.RESP_BAL), 64'd0);
        check("rst_busy", 64'(bus.BUSY), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 14; i++) begin
            single(vt[i].port, vt[i].op, vt[i].card, vt[i].amt);
            check($sformatf("vec%0d_ok", i), 64'(g_ok[0]), 64'(vt[i].ok));
            check($sformatf("vec%0d_bal", i), 64'(g_bal[0]), 64'(vt[i].bal));
        end

        // Reset in EXEC of a withdraw on card 9 must abort without ACK or write.
        op_v[0] = 0; card_v[0] = 9; amt_v[0] = 32'd1;
        bus.OP[1:0] = 2'b00; bus.CARD[3:0] = 4'd9; bus.AMOUNT[31:0] = 32'd1;
        bus.REQ = 4'b0001;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("exec_busy", 64'(bus.BUSY), 64'd1);
        RESET = 1'b0;
        #1;
        check("abort_ack", 64'(bus.ACK), 64'd0);
        check("abort_busy", 64'(bus.BUSY), 64'd0);
        bus.REQ = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            check("abort_noack", 64'(bus.ACK), 64'd0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        @(posedge CLK); #1;
        single(3, 1, 9, 32'd0);
        check("card9_after_reset", 64'(g_bal[0]), 64'd6561);

        // All four ports request and hold: strict rotation 0,1,2,3 twice.
        for (int p = 0; p < NP; p++) begin
            op_v[p] = 1; card_v[p] = p + 1; amt_v[p] = 32'd0;
        end
        run_group(4'hF, 8, 1'b1);
        for (int a = 0; a < 8; a++) check("rr_order", 64'(g_port[a]), 64'(a % NP));

        // Same-account contention: deposit then withdraw, second sees first's write.
        op_v[2] = 2; card_v[2] = 5; amt_v[2] = 32'd10;
        op_v[3] = 0; card_v[3] = 5; amt_v[3] = 32'd600;
        run_group(4'b1100, 2, 1'b0);
        check("contend_first", 64'(g_port[0]), 64'd2);
        check("contend_dep_bal", 64'(g_bal[0]), 64'd635);
        check("contend_wd_ok", 64'(g_ok[1]), 64'd1);
        check("contend_wd_bal", 64'(g_bal[1]), 64'd35);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 30; r++) begin
            logic [NP-1:0] mask;
            mask = NP'($urandom_range(1, 15));
            for (int p = 0; p < NP; p++) begin
                op_v[p]   = int'($urandom_range(0, 3));
                card_v[p] = int'($urandom_range(0, 12));
                amt_v[p]  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1500));
            end
            run_group(mask, $countones(mask), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/atm_account_arbiter.md
Name: atm_account_arbiter

Overview:
- Shared-account transaction engine and arbiter. It serves N_PORTS ATM front-end controllers that all access one balance table.
- Each front end posts a request: withdraw, inquire or deposit, with card ID and amount.
- The block grants requests round-robin and performs an atomic read-modify-write on the balance table. It returns success and the resulting balance to the granted port.
- Only one transaction is in flight at a time, so no two terminals can interleave updates to the same account.

Parameters:
N_PORTS, 4, number of requesting ATM front ends (2..8)
DB_SIZE, 10, number of valid accounts; card IDs 0..DB_SIZE-1
ID_W, 4, card ID width
AMT_W, 32, amount/balance width (unsigned)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
REQ  in  N_PORTS  per-port request level
OP  in  2*N_PORTS  per-port opcode, port p at [2p+1:2p]; 00 withdraw, 01 inquire, 10 deposit, 11 reserved
CARD  in  ID_W*N_PORTS  per-port card ID
AMOUNT  in  AMT_W*N_PORTS  per-port amount
ACK  out  N_PORTS  one-hot, one-cycle completion pulse to the served port
RESP_PORT  out  3  index of the port being acknowledged
RESP_OK  out  1  transaction succeeded
RESP_BAL  out  AMT_W  account balance after the transaction
BUSY  out  1  high from the grant cycle through the ACK cycle inclusive

Behaviour:
- Reset (RESET=0, asynchronous):
  - Outputs: ACK=0, RESP_PORT=0, RESP_OK=0, RESP_BAL=0, BUSY=0.
  - State=IDLE; round-robin pointer=N_PORTS-1, so port 0 has first priority.
  - Balance table entry i is set to i*i*i*i, truncated to AMT_W.
  - Reset mid-transaction aborts it: no ACK is issued and no write occurs.
- FSM states: IDLE -> LOAD -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any REQ bit is set, grant the first asserted port searching upward from pointer+1 with wrap-around.
  - Latch the granted port's OP, CARD and AMOUNT; set the pointer to the granted index; set BUSY=1; go to LOAD.
  - If no REQ bit is set, stay in IDLE.
- LOAD: read the table entry for the latched CARD into a balance register. An invalid card (CARD >= DB_SIZE) sets an invalid flag instead and loads 0.
- EXEC: compute result and ok from the latched OP and the loaded balance:
  - withdraw: ok when AMOUNT <= balance; new = balance - AMOUNT. AMOUNT=0 succeeds with the balance unchanged.
  - inquire: ok when balance > 0; new = balance; no write.
  - deposit: sum computed at AMT_W+1 bits. ok when no carry out; new = sum[AMT_W-1:0]. On carry, fail and leave the balance unchanged.
  - OP=11 or invalid card: fail; new = balance, which is 0 for an invalid card.
- RESP:
  - Outputs: ACK[granted]=1 for exactly this cycle, RESP_PORT=granted, RESP_OK=ok, RESP_BAL = new if ok, else the unchanged balance.
  - The table write (withdraw or deposit with ok=1 only) commits at the end of this cycle.
  - Next state is IDLE; BUSY falls with it.
- RESP_* outputs hold their last values until the next RESP cycle. Consumers sample them only while their ACK bit is high.
- Handshake rules:
  - A requester holds REQ and its operands stable until it sees ACK.
  - It drops REQ on the same edge it samples ACK=1.
  - A REQ still high in the IDLE cycle after ACK is a new request.
  - REQ deassertion before ACK is ignored; the latched transaction completes.
- Timing: with no contention, ACK arrives 3 cycles after the grant cycle. The back-to-back service period is 4 cycles per transaction.
- Fairness: the granted port becomes lowest priority. Any continuously requesting port is served within N_PORTS transactions.
- Consistency: operations on the same account from different ports are fully serialized. The second operation observes the first operation's write.

Test Plan:
- Reset, then port 1 inquires card 3 -> ACK[1] pulses 3 cycles after grant; RESP_OK=1; RESP_BAL=81.
- Port 0 withdraws 100 from card 2 (balance 16) -> RESP_OK=0, RESP_BAL=16. Then it withdraws 16 -> RESP_OK=1, RESP_BAL=0. A following inquire returns RESP_OK=0.
- All four ports request simultaneously and hold REQ -> ACK order is 0,1,2,3,0,...; each ACK is 4 cycles apart.
- Port 2 deposits 10 to card 5 while port 3 withdraws 600 from card 5 in the same cycle -> port 2 is served first (RESP_BAL=635), then port 3 (RESP_OK=1, RESP_BAL=35).
- Card 12 with any op -> RESP_OK=0, RESP_BAL=0, table unchanged. Deposit 0xFFFFFFFF to card 1 -> RESP_OK=0, RESP_BAL=1.
- Assert RESET during EXEC of a withdraw on card 9 -> no ACK; after release, inquire card 9 returns RESP_BAL=6561.
